// File: rtl/adder_rr_scheduler_pkg.sv
// Shared defaults and FSM state encoding for the round-robin adder scheduler.
package adder_rr_scheduler_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int GROUP_DEF = 4;
  localparam int NREQ_DEF  = 4;
  localparam int IDW_DEF   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/adder_rr_scheduler_adder.sv
// Brent-Kung prefix adder: ripple inside GROUP-bit groups, BK prefix tree across groups.
module bk_prefix_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);

  localparam int NG  = WIDTH / GROUP;
  localparam int LOG = (NG > 1) ? $clog2(NG) : 0;

  logic [WIDTH-1:0] p, g, c;
  logic [NG-1:0]    gg, pp;

  // Group G/P, then up-sweep and down-sweep over groups; cin is folded into group 0.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    gg = '0;
    pp = '1;
    c  = '0;
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
        pp[k] = pp[k] & p[k*GROUP+j];
      end
    end
    gg[0] = gg[0] | (pp[0] & cin);
    for (int d = 1; d < NG; d = d * 2) begin
      for (int i = 2*d - 1; i < NG; i = i + 2*d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int lvl = LOG; lvl >= 0; lvl--) begin
      for (int i = 3*(1 << lvl) - 1; i < NG; i = i + 2*(1 << lvl)) begin
        gg[i] = gg[i] | (pp[i] & gg[i-(1 << lvl)]);
      end
    end
    c[0] = cin;
    for (int k = 1; k < NG; k++) begin
      c[k*GROUP] = gg[k-1];
    end
    for (int k = 0; k < NG; k++) begin
      for (int j = 1; j < GROUP; j++) begin
        c[k*GROUP+j] = g[k*GROUP+j-1] | (p[k*GROUP+j-1] & c[k*GROUP+j-1]);
      end
    end
    sum = {gg[NG-1], p ^ c};
  end

endmodule

// File: rtl/adder_rr_scheduler_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter_onehot #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  int idx;

  // Scanning from the farthest offset back toward ptr lets the nearest request win last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one prefix adder among NREQ requesters, one op in flight.
// Optional subtraction support is enabled by defining ADDER_SCHED_SUB_EN.
module adder_rr_scheduler
  import adder_rr_scheduler_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int IDW   = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef ADDER_SCHED_SUB_EN
  input  logic [NREQ-1:0]       req_sub,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH:0]        rsp_sum,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rrPtr_q, opId_q;
  logic [WIDTH-1:0] opA_q, opB_q;
  logic             opCin_q;
  logic [WIDTH:0]   result_q;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grantId;
  logic [WIDTH-1:0] adderB;
  logic             adderCin;
  logic [WIDTH:0]   adderSum;
  logic             accept, rspFire;

  rr_arbiter_onehot #(.NREQ(NREQ), .IDW(IDW)) uArb (
    .req      (req_valid),
    .ptr      (rrPtr_q),
    .grant    (grant),
    .grant_id (grantId)
  );

`ifdef ADDER_SCHED_SUB_EN
  logic opSub_q;
  assign adderB   = opSub_q ? ~opB_q : opB_q;
  assign adderCin = opSub_q ? 1'b1 : opCin_q;
`else
  assign adderB   = opB_q;
  assign adderCin = opCin_q;
`endif

  bk_prefix_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) uAdder (
    .a   (opA_q),
    .b   (adderB),
    .cin (adderCin),
    .sum (adderSum)
  );

  assign accept    = (state_q == S_IDLE) && (|grant);
  assign rspFire   = (state_q == S_RESP) && rsp_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = opId_q;
  assign rsp_sum   = result_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = grant;
        if (accept) state_d = S_CALC;
      end
      S_CALC: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops any in-flight op; the pointer only advances once a response is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rrPtr_q  <= '0;
      opId_q   <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      opCin_q  <= 1'b0;
      result_q <= '0;
`ifdef ADDER_SCHED_SUB_EN
      opSub_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        opA_q   <= req_a[int'(grantId)*WIDTH +: WIDTH];
        opB_q   <= req_b[int'(grantId)*WIDTH +: WIDTH];
        opCin_q <= req_cin[grantId];
        opId_q  <= grantId;
`ifdef ADDER_SCHED_SUB_EN
        opSub_q <= req_sub[grantId];
`endif
      end
      if (state_q == S_CALC) result_q <= adderSum;
      if (rspFire) rrPtr_q <= (opId_q == IDW'(NREQ - 1)) ? '0 : opId_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios plus random traffic against a request-level model.
module tb_adder_rr_scheduler;

  localparam int W    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADDER_SCHED_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   reqValid = '0;
  logic [NREQ-1:0]   reqReady;
  logic [NREQ*W-1:0] reqA = '0;
  logic [NREQ*W-1:0] reqB = '0;
  logic [NREQ-1:0]   reqCin = '0;
  logic [NREQ-1:0]   reqSub = '0;
  logic              rspValid;
  logic              rspReady = 1'b0;
  logic [IDW-1:0]    rspId;
  logic [W:0]        rspSum;
  logic              busy;

  always #5 clk = ~clk;

  adder_rr_scheduler #(.WIDTH(W), .GROUP(4), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_a     (reqA),
    .req_b     (reqB),
    .req_cin   (reqCin),
`ifdef ADDER_SCHED_SUB_EN
    .req_sub   (reqSub),
`endif
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_sum   (rspSum),
    .busy      (busy)
  );

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [W:0] refResult(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic int rrWinner(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  // Request-level model: one op outstanding, response visible two cycles after acceptance.
  bit              mOut = 1'b0;
  int              mAge = 0;
  int              mPtr = 0;
  int              mId = 0;
  logic [W:0]      mSum = '0;
  logic [NREQ-1:0] acceptedMask = '0;

  always @(negedge clk) begin : compareProc
    logic [NREQ-1:0] expReady;
    int win;
    if (!rst_n) begin
      mOut = 1'b0;
      mPtr = 0;
      acceptedMask = '0;
    end else begin
      if (mOut) mAge++;
      expReady = '0;
      win = -1;
      if (!mOut) begin
        win = rrWinner(reqValid, mPtr);
        if (win >= 0) expReady[win] = 1'b1;
      end
      checkOutput("req_ready", 64'(reqReady), 64'(expReady));
      checkOutput("busy", 64'(busy), 64'(mOut));
      checkOutput("rsp_valid", 64'(rspValid), 64'(mOut && mAge >= 2));
      if (mOut && mAge >= 2) begin
        checkOutput("rsp_id", 64'(rspId), 64'(mId));
        checkOutput("rsp_sum", 64'(rspSum), 64'(mSum));
      end
      acceptedMask = expReady;
      if (win >= 0) begin
        mOut = 1'b1;
        mAge = 0;
        mId  = win;
        mSum = refResult(reqA[win*W +: W], reqB[win*W +: W], reqCin[win], reqSub[win]);
      end else if (mOut && mAge >= 2 && rspReady) begin
        mOut = 1'b0;
        mPtr = (mId + 1) % NREQ;
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    reqValid = reqValid & ~acceptedMask;
  endtask

  task automatic setReq(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    reqA[k*W +: W] = a;
    reqB[k*W +: W] = b;
    reqCin[k]      = cin;
    reqSub[k]      = SUB_EN ? sub : 1'b0;
    reqValid[k]    = 1'b1;
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic applyStimulus(input int k);
    setReq(k, randOperand(), randOperand(), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    reqValid = '0;
    rspReady = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  task automatic waitResp();
    for (int i = 0; i < 20; i++) begin
      if (rspValid) return;
      stepCycle();
    end
    checkOutput("rsp_wait", 64'(rspValid), 64'(1));
  endtask

  logic [W:0] heldSum;

  initial begin
    doReset();
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("rst_rsp_id", 64'(rspId), 64'(0));
    checkOutput("rst_rsp_sum", 64'(rspSum), 64'(0));

    // Single op from requester 2 with a full carry ripple.
    rspReady = 1'b1;
    setReq(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    #1;
    checkOutput("single_ready", 64'(reqReady), 64'(4'b0100));
    stepCycle();
    checkOutput("single_busy_calc", 64'(busy), 64'(1));
    checkOutput("single_valid_calc", 64'(rspValid), 64'(0));
    stepCycle();
    checkOutput("single_valid", 64'(rspValid), 64'(1));
    checkOutput("single_id", 64'(rspId), 64'(2));
    checkOutput("single_sum", 64'(rspSum), 64'(33'h1_0000_0000));
    checkOutput("model_single_sum", 64'(mSum), 64'(33'h1_0000_0000));
    stepCycle();
    checkOutput("single_done_busy", 64'(busy), 64'(0));

    // Carry-in with requester 3, then pointer wrap makes 0 beat 3.
    setReq(3, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("wrap_ready3", 64'(reqReady), 64'(4'b1000));
    stepCycle();
    stepCycle();
    checkOutput("cin_id", 64'(rspId), 64'(3));
    checkOutput("cin_sum", 64'(rspSum), 64'(33'h0_8000_0000));
    stepCycle();
    applyStimulus(0);
    applyStimulus(3);
    #1;
    checkOutput("wrap_ready0", 64'(reqReady), 64'(4'b0001));

    // All requesters active: grants rotate 0,1,2,3,0.
    doReset();
    rspReady = 1'b1;
    for (int k = 0; k < NREQ; k++) applyStimulus(k);
    for (int n = 0; n < 5; n++) begin
      waitResp();
      checkOutput("rr_order", 64'(rspId), 64'(n % NREQ));
      stepCycle();
      for (int k = 0; k < NREQ; k++) if (!reqValid[k]) applyStimulus(k);
    end

    // Backpressure: response held for five cycles with another request waiting.
    doReset();
    rspReady = 1'b0;
    setReq(1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    heldSum = refResult(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    waitResp();
    applyStimulus(0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 64'(rspValid), 64'(1));
      checkOutput("bp_id", 64'(rspId), 64'(1));
      checkOutput("bp_sum", 64'(rspSum), 64'(heldSum));
      checkOutput("bp_ready", 64'(reqReady), 64'(0));
      stepCycle();
    end
    rspReady = 1'b1;
    stepCycle();
    checkOutput("bp_done_busy", 64'(busy), 64'(0));
    checkOutput("bp_next_ready", 64'(reqReady), 64'(4'b0001));

    // Reset while in CALC: pointer returns to 0, so requester 1 beats a stale pointer of 3.
    doReset();
    rspReady = 1'b1;
    applyStimulus(2);
    stepCycle();
    stepCycle();
    stepCycle();
    applyStimulus(3);
    applyStimulus(1);
    stepCycle();
    checkOutput("midop_calc_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    checkOutput("midop_rsp_valid", 64'(rspValid), 64'(0));
    checkOutput("midop_busy", 64'(busy), 64'(0));
    checkOutput("midop_rsp_sum", 64'(rspSum), 64'(0));
    applyStimulus(3);
    #1;
    checkOutput("midop_grant", 64'(reqReady), 64'(4'b0010));

`ifdef ADDER_SCHED_SUB_EN
    doReset();
    rspReady = 1'b1;
    setReq(0, 32'd5, 32'd7, 1'b0, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("sub_sum", 64'(rspSum), 64'(33'h0_FFFF_FFFE));
    checkOutput("model_sub_sum", 64'(mSum), 64'(33'h0_FFFF_FFFE));
`endif

    // Random traffic with random backpressure and occasional resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      stepCycle();
      for (int k = 0; k < NREQ; k++) begin
        if (!reqValid[k] && $urandom_range(99) < 40) applyStimulus(k);
      end
      rspReady = ($urandom_range(99) < 70);
      rst_n    = ($urandom_range(499) != 0);
    end
    rst_n = 1'b1;
    stepCycle();
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one registered Brent-Kung-style prefix adder datapath among NREQ requesters. Arbitration is round-robin, with one operation in flight at a time.
- Each requester presents operands with a valid/ready handshake.
- The result, with carry-out, returns to the winning requester on a response channel tagged with the requester ID.
- Sits between ALU/address-generation clients and the shared adder in the execute stage.

Parameters:
- WIDTH, 32, operand width; must be a multiple of GROUP.
- GROUP, 4, adder group size; passed to the adder instance.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  packed operand A; requester k occupies [k*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B.
- req_cin  in  NREQ  carry-in per requester.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  ID of the requester that owns the result.
- rsp_sum  out  WIDTH+1  {carry_out, sum}.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, CALC, RESP. Encoding is 2-bit: IDLE=0, CALC=1, RESP=2.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Assert req_ready only for the winner, combinationally, in that same cycle.
  - On the handshake: latch A, B, cin and id into operand registers; go to CALC.
- CALC: exactly one cycle.
  - Operand registers drive the adder; its WIDTH+1 output is captured into the result register.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_sum hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: rr_ptr <= (id+1) mod NREQ, then go to IDLE.
- Latency: request accept to rsp_valid is 2 cycles. Throughput is at most 1 op per 3 cycles.
- req_ready is 0 in CALC and RESP, so no new request is accepted while one is outstanding.
- Requests that are valid but not granted must stay asserted; the block does not queue them.
- Fairness: the requester that was just served has lowest priority next time. With all requesters active, grants rotate 0,1,2,…,NREQ-1,0.
- Sum arithmetic: unsigned, {cout,sum} = A + B + cin, WIDTH+1 bits, no truncation. The adder output is taken raw; no sign/magnitude post-processing.
- Reset, when rst_n=0 at a clk edge:
  - State=IDLE, rr_ptr=0, operand/result registers=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0.
  - Reset mid-operation drops the in-flight op silently; no response is issued.
- rsp_ready held high in RESP: the response completes in that cycle. The next grant can occur in the following IDLE cycle, never the same cycle.
- Single requester active: it is granted every op regardless of rr_ptr.

Optional Feature:
- Macro: ADDER_SCHED_SUB_EN.
- Defined:
  - Adds input port req_sub [NREQ], latched with the operands.
  - When the latched sub bit is 1, the adder receives ~B and carry-in 1, ignoring req_cin. Result = A - B as {borrow_n, diff}, where bit WIDTH=1 means no borrow.
- Undefined: port absent; addition only.

Decomposition:
- Shared define header holds:
  - WIDTH, GROUP, NREQ and IDW defaults.
  - FSM state constants S_IDLE, S_CALC, S_RESP.
- One natural sub-module: rr_arbiter_onehot, with inputs req[NREQ] and ptr[IDW] and outputs grant[NREQ] one-hot and grant_id[IDW]. It is purely combinational.
- The adder is instantiated unchanged inside the scheduler.

Test Plan:
- Single op:
  - Stimulus: requester 2, A=0xFFFFFFFF, B=1, cin=0, rsp_ready=1.
  - Response: req_ready[2] in the accept cycle; rsp_valid 2 cycles later with rsp_id=2, rsp_sum=0x1_00000000; busy high for the duration.
- Round-robin:
  - Stimulus: all 4 req_valid held high with distinct operands; rsp_ready=1.
  - Response: grant order 0,1,2,3,0; each rsp_sum matches the reference model.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP.
  - Response: rsp_valid, rsp_id and rsp_sum remain stable; req_ready stays 0; completes on the cycle rsp_ready rises.
- Reset mid-op:
  - Stimulus: assert rst_n=0 in CALC.
  - Response: next cycle rsp_valid=0, busy=0, rr_ptr=0; the next grant goes to the lowest set req_valid.
- Carry-in/wrap:
  - Stimulus: requester 3 only, A=0x7FFFFFFF, B=0, cin=1; then requester 0.
  - Response: first result 0x0_80000000; rr_ptr wraps so requester 0 is granted next.
- With ADDER_SCHED_SUB_EN:
  - Stimulus: A=5, B=7, sub=1.
  - Response: rsp_sum=0x0_FFFFFFFE, with bit 32=0 indicating borrow.
